// File: rtl/dlfloat16_div.sv
// dlfloat16_div: iterative DLFloat16 divider using restoring division, one quotient bit per clock
module dlfloat16_div #(
    parameter logic [3:0] OPCODE = 4'b0011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [3:0]  ena,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] c_div,
    output logic [4:0]  exception_flags
);
    typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;
    state_t state, state_nx;
    logic        sgn;
    logic [5:0]  ea, eb;
    logic [9:0]  mb;
    logic [10:0] r, q, r_nx, q_nx;
    logic [3:0]  cnt;
    logic        spec, spec_ones;
    logic [4:0]  spec_flg, spec_flg_now;
    logic        go, a_zero, b_zero, a_nan, b_nan, spec_now, ge;
    logic [7:0]  e;
    logic [8:0]  mant;
    logic        inexact, ovf, unf;
    logic [15:0] norm_res;
    assign go           = state == IDLE && start && ena == OPCODE;
    assign a_zero       = a[14:9] == 6'd0;
    assign b_zero       = b[14:9] == 6'd0;
    assign a_nan        = a == 16'hFFFF;
    assign b_nan        = b == 16'hFFFF;
    assign spec_now     = a_nan | b_nan | a_zero | b_zero;
    assign spec_flg_now = (a_nan | b_nan | (a_zero & b_zero)) ? 5'b10000 : b_zero ? 5'b00001 : 5'b00000;
    assign ge           = r >= {1'b0, mb};
    assign r_nx         = (ge ? r - {1'b0, mb} : r) << 1;
    assign q_nx         = {q[9:0], ge};
    // Normalisation and range check of the finished quotient; e is read as signed
    always_comb begin
        mant     = q[10] ? q[9:1] : q[8:0];
        e        = {2'b00, ea} - {2'b00, eb} + 8'd30 + {7'd0, q[10]};
        ovf      = $signed(e) > 8'sd62;
        unf      = $signed(e) < 8'sd1;
        inexact  = (q[10] & q[0]) | (r != 11'd0);
        norm_res = ovf ? {sgn, 15'h7DFE} : unf ? 16'h0000 : {sgn, e[5:0], mant};
    end
    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // Next-state: specials skip the iteration and go straight to NORM
    always_comb begin
        state_nx = state == IDLE ? (go ? (spec_now ? NORM : DIV) : IDLE) :
                   state == DIV  ? (cnt == 4'd10 ? NORM : DIV) : IDLE;
    end
    // Outputs derived from state
    always_comb begin
        busy = state != IDLE;
    end
    // Datapath: operand capture, quotient iteration and result registration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn <= 1'b0; ea <= 6'd0; eb <= 6'd0; mb <= 10'd0;
            r <= 11'd0; q <= 11'd0; cnt <= 4'd0;
            spec <= 1'b0; spec_ones <= 1'b0; spec_flg <= 5'd0;
            done <= 1'b0; c_div <= 16'd0; exception_flags <= 5'd0;
        end else begin
            done <= state == NORM;
            if (go) begin
                sgn       <= a[15] ^ b[15];
                ea        <= a[14:9];
                eb        <= b[14:9];
                mb        <= {1'b1, b[8:0]};
                r         <= {2'b01, a[8:0]};
                q         <= 11'd0;
                cnt       <= 4'd0;
                spec      <= spec_now;
                spec_ones <= a_nan | b_nan | b_zero;
                spec_flg  <= spec_flg_now;
            end
            if (state == DIV) begin
                r   <= r_nx;
                q   <= q_nx;
                cnt <= cnt + 4'd1;
            end
            if (state == NORM) begin
                c_div           <= spec ? {16{spec_ones}} : norm_res;
                exception_flags <= spec ? spec_flg : {1'b0, inexact, ovf, unf, 1'b0};
            end
        end
    end
endmodule

// File: tb/tb_dlfloat16_div.sv
// tb_dlfloat16_div: scoreboard bench for the DLFloat16 divider with directed vectors
module tb_dlfloat16_div;
    localparam logic [3:0] OP = 4'b0011;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [15:0] a = 16'd0, b = 16'd0, c_div;
    logic [3:0]  ena = 4'd0;
    logic        busy, done;
    logic [4:0]  exception_flags;
    int          n_cmp = 0, n_bad = 0, cyc = 0;
    typedef struct {logic [15:0] c; logic [4:0] f; int at;} exp_t;
    exp_t sb[$];

    dlfloat16_div #(.OPCODE(OP)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .ena(ena), .start(start),
        .busy(busy), .done(done), .c_div(c_div), .exception_flags(exception_flags)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) chk("unexpected_done", {31'd0, done}, 32'd0);
            else begin
                exp_t x;
                x = sb.pop_front();
                chk("c_div", {16'd0, c_div}, {16'd0, x.c});
                chk("flags", {27'd0, exception_flags}, {27'd0, x.f});
                chk("latency", cyc, x.at);
            end
        end
    end

    // Issue one operation from a negedge; optionally pulse a stray start mid-DIV
    task automatic run(input logic [15:0] ta, input logic [15:0] tb_, input logic [15:0] c,
                       input logic [4:0] f, input int lat, input bit inj);
        bit seen = 0;
        a = ta; b = tb_; ena = OP; start = 1'b1;
        sb.push_back('{c, f, cyc + 1 + lat});
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            start = inj && i == 3;
            if (inj && i == 3) begin a = 16'h4100; b = 16'h4000; end
            if (done) seen = 1;
            else chk("busy_during_op", {31'd0, busy}, 32'd1);
        end
        start = 1'b0;
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        chk("idle_at_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_c_div", {16'd0, c_div}, 32'd0);
        chk("rst_flags", {27'd0, exception_flags}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run(16'h3E00, 16'h3E00, 16'h3E00, 5'b00000, 12, 0);
        run(16'h4100, 16'h4000, 16'h3F00, 5'b00000, 12, 0);
        run(16'h3E00, 16'h4100, 16'h3AAA, 5'b01000, 12, 0);
        run(16'h4300, 16'h4100, 16'h4000, 5'b00000, 12, 0);
        run(16'hC300, 16'h4100, 16'hC000, 5'b00000, 12, 0);
        run(16'hBE00, 16'h0000, 16'hFFFF, 5'b00001, 1, 0);
        run(16'h0000, 16'h0000, 16'hFFFF, 5'b10000, 1, 0);
        run(16'hFFFF, 16'h3E00, 16'hFFFF, 5'b10000, 1, 0);
        run(16'h0000, 16'h4000, 16'h0000, 5'b00000, 1, 0);
        run(16'h7C00, 16'h0200, 16'h7DFE, 5'b00100, 12, 0);
        run(16'hFC00, 16'h0200, 16'hFDFE, 5'b00100, 12, 0);
        run(16'h0200, 16'h7C00, 16'h0000, 5'b00010, 12, 0);
        run(16'h3E00, 16'h4100, 16'h3AAA, 5'b01000, 12, 1);
        repeat (15) @(negedge clk);
        a = 16'h4100; b = 16'h4000; ena = 4'b0010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("wrong_ena_busy", {31'd0, busy}, 32'd0);
        repeat (14) @(negedge clk);
        chk("wrong_ena_c_div_held", {16'd0, c_div}, 32'h3AAA);
        a = 16'h3E00; b = 16'h3E00; ena = OP; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_div_busy", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_c_div", {16'd0, c_div}, 32'd0);
        chk("async_rst_flags", {27'd0, exception_flags}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(negedge clk);
        chk("no_done_after_rst", {16'd0, c_div}, 32'd0);
        run(16'h3E00, 16'h3E00, 16'h3E00, 5'b00000, 12, 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dlfloat16_div.md
Name: dlfloat16_div

Overview:
- Iterative DLFloat16 divider: c_div = a / b.
- DLFloat16 format: sign [15], 6-bit exponent [14:9] with bias 31, 9-bit mantissa [8:0] with hidden 1.
- It is the inverse-operation companion to the FPU's single-cycle-registered multiplier, selected by opcode on the shared ena bus.
- Uses restoring division, one quotient bit per clock, with a start/busy/done handshake.
- Exception flags use the FPU's common 5-bit ordering.

Parameters:
- OPCODE, 4'b0011, ena value that selects division; start is ignored under any other value.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- a  in  16  dividend (DLFloat16)
- b  in  16  divisor (DLFloat16)
- ena  in  4  FPU operation select
- start  in  1  request; sampled only in IDLE
- busy  out  1  high while not in IDLE
- done  out  1  one-cycle pulse when c_div and exception_flags update
- c_div  out  16  registered quotient, held until the next completion
- exception_flags  out  5  {invalid, inexact, overflow, underflow, div_zero}, registered with c_div

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; c_div=0; exception_flags=0; done=0; busy=0.
  - Internal counter and remainder are cleared.
  - An operation in flight is discarded with no done pulse.
- IDLE, on the edge with start=1 and ena==OPCODE:
  - Capture sa, sb, ea, eb, ma={1,a[8:0]}, mb={1,b[8:0]}.
  - Classify the operands. Zero means operand[14:0]==0; an exponent field of 0 with a nonzero mantissa is also flushed to zero. NaN/inf means operand==16'hFFFF.
  - If any special case applies, go to NORM with the result preselected. Otherwise go to DIV with count=0 and remainder R=ma (11 bits).
  - start with another ena value, or start while busy, is ignored; outputs are unchanged.
- Special-case priority (result, flags):
  1. a or b == FFFF: FFFF, invalid.
  2. a zero and b zero: FFFF, invalid.
  3. b zero: FFFF, div_zero.
  4. a zero: 0000, no flags.
- DIV (exactly 11 clocks):
  - Each clock: if R >= mb then q bit=1 and R=R-mb, else q bit=0. Then R=R<<1. q fills MSB-first into q[10:0].
  - After count==10, go to NORM.
- NORM (1 clock):
  - Normalise:
    - q[10]=1: mant=q[9:1], lost=q[0].
    - q[10]=0: mant=q[8:0], lost=0.
  - Exponent, signed 8-bit: e = ea - eb + 31 - (q[10]?0:1).
  - inexact = lost | (R!=0). Rounding is truncation toward zero.
  - Result selection:
    - e > 62: overflow=1, c_div = sign ? FDFE : 7DFE.
    - e < 1: underflow=1, c_div=0000.
    - otherwise: c_div = {sa^sb, e[5:0], mant}.
  - inexact is still reported when overflow or underflow is set.
  - Register c_div and exception_flags, pulse done=1, return to IDLE.
- Latency:
  - done is high in the cycle after the 12th rising edge following the start-sampling edge for normal operands.
  - For special cases, done follows the 1st edge after the start-sampling edge.
- Throughput: a new start is accepted in the cycle done is high (state is IDLE).
- Input stability: a and b need only be valid on the start edge.
- Flags reflect only the latest completed operation; they are not sticky across operations.

Test Plan:
- a=3E00 (1.0), b=3E00 -> c_div=3E00, flags=00000; done exactly 12 clocks after start; busy high throughout.
- a=4100 (3.0), b=4000 (2.0) -> 3F00 (1.5), flags=00000. a=3E00, b=4100 -> 3AAA, flags=01000 (inexact).
- Specials:
  - a=BE00, b=0000 -> FFFF, flags=00001.
  - a=0000, b=0000 -> FFFF, flags=10000.
  - a=FFFF, b=3E00 -> FFFF, flags=10000.
  - a=0000, b=4000 -> 0000, flags=00000.
  - Each completes with done 1 clock after start.
- Range limits:
  - a=7C00, b=0200 -> 7DFE, flags=00100.
  - a=FC00, b=0200 -> FDFE, flags=00100.
  - a=0200, b=7C00 -> 0000, flags=00010.
- Handshake:
  - start pulsed mid-DIV with new operands -> ignored; first result unaffected; single done pulse.
  - start with ena=0010 -> no busy, no done.
- Reset:
  - rst_n low at DIV cycle 5 -> outputs immediately 0, state IDLE.
  - After release, 3E00/3E00 completes normally in 12 clocks.
